// File: rtl/control_unit_multicycle.sv
// control_unit_multicycle: Moore FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle RV32I core
module control_unit_multicycle #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned ALUOP_W         = 3,
  parameter int unsigned IMM_SRC_W       = 3,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 alu_lt,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 branch,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic                 halt,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instret
);
  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB,
    BRANCH, JAL, JALR, LINK, LUI, AUIPC, HALT, TRAP
  } state_t;
  localparam state_t ILL_NEXT = TRAP_ON_ILLEGAL ? TRAP : FETCH;
  state_t state, nxt, dec;
  logic unk, bad_br, taken, retire, pcw, irw, rw, mw;
  logic [2:0] op, imm;
  assign bad_br = funct3[2:1] == 2'b01;
  assign taken  = funct3[2] ? (alu_lt ^ funct3[0]) : (zero ^ funct3[0]);
  assign unk    = dec == TRAP;
  assign retire = state == MEMWB || state == ALUWB || (state == BRANCH && !bad_br) || (state == MEMWR && mem_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state   <= nxt;
      instret <= retire ? instret + CNT_W'(1) : instret;
    end
  end
  // TRAP doubles as the "no match" sentinel from the opcode decoder
  always_comb begin
    dec = TRAP;
    case (opcode)
      7'b0000011, 7'b0100011: dec = MEMADR;
      7'b0110011: dec = EXECR;
      7'b0010011: dec = EXECI;
      7'b1100011: dec = BRANCH;
      7'b1101111: dec = JAL;
      7'b1100111: dec = JALR;
      7'b0110111: dec = LUI;
      7'b0010111: dec = AUIPC;
      7'b1110011: dec = HALT;
      default:    dec = TRAP;
    endcase
    case (state)
      FETCH:                         nxt = mem_ready ? DECODE : FETCH;
      DECODE:                        nxt = unk ? ILL_NEXT : dec;
      MEMADR:                        nxt = opcode[5] ? MEMWR : MEMRD;
      MEMRD:                         nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:                         nxt = mem_ready ? FETCH : MEMWR;
      EXECR, EXECI, LINK, LUI, AUIPC: nxt = ALUWB;
      BRANCH:                        nxt = bad_br ? ILL_NEXT : FETCH;
      JAL, JALR:                     nxt = LINK;
      HALT:                          nxt = HALT;
      TRAP:                          nxt = TRAP;
      default:                       nxt = FETCH;
    endcase
  end
  always_comb begin
    mem_read   = 1'b0;
    adr_src    = 1'b0;
    branch     = 1'b0;
    halt       = 1'b0;
    illegal    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    op         = 3'b000;
    imm        = 3'b000;
    pcw        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1; alu_src_b = 2'b10; op = 3'b010; result_src = 2'b10;
        irw = mem_ready; pcw = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01; imm = 3'b010; op = 3'b010; illegal = unk;
      end
      MEMADR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; op = 3'b010; imm = opcode[5] ? 3'b001 : 3'b000;
      end
      MEMRD:  begin adr_src = 1'b1; mem_read = 1'b1; end
      MEMWB:  begin result_src = 2'b01; rw = 1'b1; end
      MEMWR:  begin adr_src = 1'b1; mw = 1'b1; end
      EXECR:  alu_src_a = 2'b10;
      EXECI:  begin alu_src_a = 2'b10; alu_src_b = 2'b01; op = 3'b001; end
      ALUWB:  rw = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b10; op = 3'b100; branch = 1'b1;
        pcw = taken && !bad_br; illegal = bad_br;
      end
      JAL: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01; imm = 3'b011; op = 3'b101; result_src = 2'b10; pcw = 1'b1;
      end
      JALR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; op = 3'b101; result_src = 2'b10; pcw = 1'b1;
      end
      LINK:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; op = 3'b010; end
      LUI:    begin alu_src_a = 2'b11; alu_src_b = 2'b01; imm = 3'b100; op = 3'b110; end
      AUIPC:  begin alu_src_a = 2'b01; alu_src_b = 2'b01; imm = 3'b100; op = 3'b110; end
      HALT:   halt = 1'b1;
      TRAP:   begin halt = 1'b1; illegal = 1'b1; end
      default: ;
    endcase
  end
  // writes are suppressed for the whole reset cycle so nothing half-completes
  assign pc_write  = pcw && !rst;
  assign ir_write  = irw && !rst;
  assign reg_write = rw && !rst;
  assign mem_write = mw && !rst;
  assign alu_op    = ALUOP_W'(op);
  assign imm_src   = IMM_SRC_W'(imm);
endmodule

// File: tb/tb_control_unit_multicycle.sv
// tb_control_unit_multicycle: random instruction streams checked against per-instruction cycle/write budgets
module tb_control_unit_multicycle;
  localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  logic clk = 1'b0, rst = 1'b0, zero = 1'b0, alu_lt = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic pc_write_a, ir_write_a, reg_write_a, mem_read_a, mem_write_a, adr_src_a, branch_a, halt_a, illegal_a;
  logic pc_write_b, ir_write_b, reg_write_b, mem_read_b, mem_write_b, adr_src_b, branch_b, halt_b, illegal_b;
  logic [1:0] src_a_a, src_b_a, rsrc_a, src_a_b, src_b_b, rsrc_b;
  logic [2:0] alu_op_a, imm_a, alu_op_b, imm_b;
  logic [31:0] instret_a;
  logic [3:0] instret_b;
  logic [20:0] vec_a, vec_b;
  int total = 0, bad = 0, retired = 0;
  logic [6:0] ops [9] = '{OP_LD, OP_ST, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  logic [2:0] brf [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  control_unit_multicycle dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .alu_lt(alu_lt),
    .mem_ready(mem_ready), .pc_write(pc_write_a), .ir_write(ir_write_a), .reg_write(reg_write_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .adr_src(adr_src_a), .branch(branch_a),
    .alu_src_a(src_a_a), .alu_src_b(src_b_a), .result_src(rsrc_a), .alu_op(alu_op_a),
    .imm_src(imm_a), .halt(halt_a), .illegal(illegal_a), .instret(instret_a));
  control_unit_multicycle #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .alu_lt(alu_lt),
    .mem_ready(mem_ready), .pc_write(pc_write_b), .ir_write(ir_write_b), .reg_write(reg_write_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .adr_src(adr_src_b), .branch(branch_b),
    .alu_src_a(src_a_b), .alu_src_b(src_b_b), .result_src(rsrc_b), .alu_op(alu_op_b),
    .imm_src(imm_b), .halt(halt_b), .illegal(illegal_b), .instret(instret_b));

  assign vec_a = {pc_write_a, ir_write_a, reg_write_a, mem_read_a, mem_write_a, adr_src_a, branch_a,
                  src_a_a, src_b_a, rsrc_a, alu_op_a, imm_a, halt_a, illegal_a};
  assign vec_b = {pc_write_b, ir_write_b, reg_write_b, mem_read_b, mem_write_b, adr_src_b, branch_b,
                  src_a_b, src_b_b, rsrc_b, alu_op_b, imm_b, halt_b, illegal_b};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic to_neg(input logic mr);
    mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    to_neg(1'b1);
    chk("rst_writes_a", {pc_write_a, ir_write_a, reg_write_a, mem_write_a}, 0);
    chk("rst_writes_b", {pc_write_b, ir_write_b, reg_write_b, mem_write_b}, 0);
    to_pos();
    rst = 1'b0;
    retired = 0;
  endtask

  // one instruction from FETCH back to FETCH; fs fetch stalls, ms memory stalls
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic lt,
                     input int fs, input int ms);
    bit ld = op == OP_LD, st = op == OP_ST, br = op == OP_BR;
    bit jmp = op == OP_JAL || op == OP_JALR, mem = ld || st, wb = !(st || br), tk;
    int n, nrw = 0, nrwb = 0, nmw = 0, npc = 0, nir = 0, nrd = 0, last = 0;
    logic [1:0] rs_at = 2'b11;
    logic mr;
    case (f3)
      3'b000:         tk = z;
      3'b001:         tk = !z;
      3'b100, 3'b110: tk = lt;
      default:        tk = !lt;
    endcase
    n = (br ? 3 : (ld || jmp) ? 5 : 4) + fs + (mem ? ms : 0);
    opcode = op; funct3 = f3; zero = z; alu_lt = lt;
    for (int c = 1; c <= n; c++) begin
      if (c <= fs) mr = 1'b0;
      else if (c == fs + 1) mr = 1'b1;
      else if (mem && c >= fs + 4 && c < fs + 4 + ms) mr = 1'b0;
      else if (mem && c == fs + 4 + ms) mr = 1'b1;
      else mr = 1'($urandom);
      to_neg(mr);
      nrw += int'(reg_write_a); nrwb += int'(reg_write_b); nmw += int'(mem_write_a);
      npc += int'(pc_write_a); nir += int'(ir_write_a); nrd += int'(mem_read_a);
      if (reg_write_a) begin last = c; rs_at = rsrc_a; end
      to_pos();
    end
    retired++;
    chk("reg_write_cnt", nrw, 32'(wb));
    chk("reg_write_cnt_b", nrwb, 32'(wb));
    if (wb) begin
      chk("reg_write_cycle", last, n);
      chk("wb_result_src", rs_at, ld ? 1 : 0);
    end
    chk("mem_write_cnt", nmw, st ? ms + 1 : 0);
    chk("pc_write_cnt", npc, 1 + int'((br && tk) || jmp));
    chk("ir_write_cnt", nir, 1);
    chk("mem_read_cnt", nrd, fs + 1 + (ld ? ms + 1 : 0));
    chk("instret_a", instret_a, retired);
    chk("instret_b", instret_b, retired % 16);
    chk("halt", {halt_a, halt_b}, 0);
  endtask

  initial begin
    do_reset();
    to_neg(1'b0);
    chk("first_vec_a", vec_a, {7'b0001000, 2'b00, 2'b10, 2'b10, 3'b010, 3'b000, 2'b00});
    chk("first_vec_b", vec_b, {7'b0001000, 2'b00, 2'b10, 2'b10, 3'b010, 3'b000, 2'b00});
    chk("first_instret", instret_a, 0);
    to_pos();
    run(OP_I, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_LD, 3'b010, 1'b0, 1'b0, 0, 3);
    run(OP_BR, 3'b000, 1'b1, 1'b0, 0, 0);
    run(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_BR, 3'b111, 1'b0, 1'b0, 1, 0);
    run(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run(OP_ST, 3'b010, 1'b0, 1'b0, 2, 2);
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 8)];
      run(op, op == OP_BR ? brf[$urandom_range(0, 5)] : 3'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 2), $urandom_range(0, 3));
    end
    opcode = 7'h7F;
    to_neg(1'b1);
    to_pos();
    to_neg(1'($urandom));
    chk("ill_decode_a", illegal_a, 1);
    chk("ill_decode_b", illegal_b, 1);
    to_pos();
    to_neg(1'b0);
    chk("nop_fetch_b", {mem_read_b, illegal_b, halt_b}, 3'b100);
    to_pos();
    for (int i = 0; i < 4; i++) begin
      to_neg(1'b0);
      chk("trap_held", {halt_a, illegal_a, mem_read_a, pc_write_a}, 4'b1100);
      chk("trap_instret", instret_a, retired);
      to_pos();
    end
    chk("nop_instret_b", instret_b, retired % 16);
    do_reset();
    for (int i = 0; i < 3; i++) run(ops[$urandom_range(2, 8)], 3'b000, 1'($urandom), 1'($urandom), 0, 0);
    opcode = OP_ST;
    to_neg(1'b1); to_pos();
    to_neg(1'b1); to_pos();
    to_neg(1'b1); to_pos();
    to_neg(1'b0);
    chk("memwr_wait", {mem_write_a, adr_src_a}, 2'b11);
    to_pos();
    rst = 1'b1;
    to_neg(1'b1);
    chk("memwr_rst_a", mem_write_a, 0);
    chk("memwr_rst_b", mem_write_b, 0);
    to_pos();
    rst = 1'b0;
    retired = 0;
    to_neg(1'b0);
    chk("post_rst_fetch", {mem_read_a, adr_src_a, src_b_a}, 4'b1010);
    chk("post_rst_instret", {28'd0, instret_b} | instret_a, 0);
    to_pos();
    opcode = OP_BR; funct3 = 3'b010; zero = 1'b1;
    to_neg(1'b1); to_pos();
    to_neg(1'b1); to_pos();
    to_neg(1'b1);
    chk("br_bad_b", {pc_write_b, illegal_b}, 2'b01);
    chk("br_bad_a", {pc_write_a, illegal_a}, 2'b01);
    to_pos();
    to_neg(1'b0);
    chk("br_bad_trap_a", {halt_a, illegal_a}, 2'b11);
    chk("br_bad_fetch_b", {mem_read_b, halt_b}, 2'b10);
    chk("br_bad_instret", {28'd0, instret_b} | instret_a, 0);
    to_pos();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit_multicycle.md
# control_unit_multicycle

Multi-cycle main control unit for the RV32I core. It replaces per-opcode combinational decode with a Moore-style state machine that sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port. It adds a memory-ready handshake, a retired-instruction counter, a halt mode and an illegal-opcode trap. It drives the same datapath controls (ALUOp, ImmSrc, RegWrite, MemWrite, …) plus multi-cycle muxes.

## Interface
- CNT_W, 32, width of retired-instruction counter
- ALUOP_W, 3, alu_op width (≥3); bits above [2:0] always 0
- IMM_SRC_W, 3, imm_src width (≥3); bits above [2:0] always 0
- TRAP_ON_ILLEGAL, 1, 1: illegal opcode → TRAP state; 0: treated as NOP
- One clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- alu_lt  in  1  ALU less-than flag (signedness chosen by ALU from funct3)
- mem_ready  in  1  memory accepts/completes the current access this cycle
- pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, branch  out  1 each
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 reg, 11 zero
- alu_src_b  out  2  00 rs2 reg, 01 imm, 10 const 4
- result_src  out  2  00 ALUOut reg, 01 mem-data reg, 10 ALU result direct
- alu_op  out  ALUOP_W  000 R, 001 I, 010 add, 100 branch compare, 101 jump, 110 upper-imm
- imm_src  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U
- halt  out  1  core stopped (HALT or TRAP)
- illegal  out  1  unknown opcode or branch funct3
- instret  out  CNT_W  retired-instruction count

## Operation
- Outputs decode from state only, except where noted. Any output not listed for a state is 0.
- FETCH: mem_read=1, a=00, b=10, alu_op=010, result_src=10. ir_write=pc_write=mem_ready. mem_ready → DECODE, else hold.
- DECODE: a=01, b=01, imm_src=010, alu_op=010 (branch target into ALUOut). Next state by opcode:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR; 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL; 1100111 → JALR
  - 0110111 → LUI; 0010111 → AUIPC
  - 1110011 → HALT
  - other: illegal=1 (combinational), then → TRAP if TRAP_ON_ILLEGAL, else → FETCH.
- MEMADR: a=10, b=01, alu_op=010, imm_src=001 for store, else 000. Load → MEMRD; store → MEMWR.
- MEMRD: adr_src=1, mem_read=1; hold until mem_ready → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWR: adr_src=1, mem_write=1 held continuously until mem_ready → FETCH.
- EXECR: a=10, b=00, alu_op=000 → ALUWB.
- EXECI: a=10, b=01, imm_src=000, alu_op=001 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH: a=10, b=00, alu_op=100, branch=1, result_src=00.
  - pc_write = taken, where taken = funct3[2] ? (alu_lt^funct3[0]) : (zero^funct3[0]).
  - funct3 ∈ {010,011}: illegal=1, pc_write=0, handled as for an illegal opcode.
  - Otherwise → FETCH.
- JAL: a=01, b=01, imm_src=011, alu_op=101, result_src=10, pc_write=1 → LINK.
- JALR: a=10, b=01, imm_src=000, alu_op=101, result_src=10, pc_write=1 → LINK. Target bit 0 is cleared by the datapath.
- LINK: a=01, b=10, alu_op=010 → ALUWB.
- LUI: a=11, b=01, imm_src=100, alu_op=110 → ALUWB.
- AUIPC: a=01, b=01, imm_src=100, alu_op=110 → ALUWB.
- HALT: halt=1, terminal until rst.
- TRAP: halt=1, illegal=1, terminal until rst.
- instret increments (mod 2^CNT_W, wraps silently) on leaving MEMWB, ALUWB, BRANCH (legal funct3 only), or MEMWR with mem_ready. Illegal NOPs, HALT and TRAP do not count.

## Timing
- Reset: state=FETCH, instret=0. While rst=1, pc_write, ir_write, reg_write and mem_write are forced 0 regardless of state.
- First cycle after reset: mem_read=1, a=00, b=10, alu_op=010, result_src=10, everything else 0.
- Reset asserted in any state, including mid-wait in MEMRD/MEMWR, returns to FETCH on the next edge. No write completes.
- Cycles per instruction with mem_ready=1: branch 3; R/I/LUI/AUIPC/store 4; load/JAL/JALR 5. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset then addi (0x00500093), mem_ready=1: FETCH→DECODE→EXECI→ALUWB. reg_write=1 only in cycle 4; instret 0→1 after cycle 4.
- lw with mem_ready low 3 cycles in MEMRD: mem_read and adr_src stay 1 for 4 cycles. MEMWB follows. Total 8 cycles; instret +1.
- beq with zero=1: pc_write=1 in cycle 3. Same instruction with zero=0: pc_write=0. bgeu (funct3=111) with alu_lt=0: taken.
- jal: pc_write in cycle 3 (imm_src=011); LINK; reg_write with result_src=00 in cycle 5.
- Opcode 0x7F: TRAP_ON_ILLEGAL=1 → halt=illegal=1 held, instret frozen. TRAP_ON_ILLEGAL=0 → illegal pulses in DECODE, then FETCH.
- rst pulsed during MEMWR wait: mem_write=0 in the reset cycle, FETCH next, instret=0. With CNT_W=4, 16 retirements wrap instret to 0.
